// File: rtl/memory_port_arbiter_pkg.sv
// Shared processor-side definitions for the memory port arbiter: FSM state
// encodings, access attribute encodings and requester identifiers.
package memory_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam int unsigned TCNT_W = 8;

endpackage

// File: rtl/access_timeout_counter.sv
// Counts ACCESS cycles since the last clear; terminal count flags an access
// that has waited TIMEOUT_CYCLES cycles for the memory to complete.
module access_timeout_counter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [TCNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + TCNT_W'(1);
    end
  end

  assign o_terminal = (r_count == TCNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a fetch and a data
// requester, with registered memory-side outputs and an access timeout.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        F_Req,
  input  logic [31:0] F_Addr,
  output logic        F_Gnt,
  output logic        F_Done,
  output logic        F_Err,
  output logic [31:0] F_RData,
  input  logic        D_Req,
  input  logic        D_RW,
  input  logic [1:0]  D_Size,
  input  logic        D_SU,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  output logic        D_Gnt,
  output logic        D_Done,
  output logic        D_Err,
  output logic [31:0] D_RData,
  output logic        MOV,
  output logic        RW,
  output logic [1:0]  SIZE,
  output logic        SU,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  input  logic        MOC
);

  logic [1:0]  r_state;
  logic        r_mov;
  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_su;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_f_gnt, r_f_done, r_f_err;
  logic        r_d_gnt, r_d_done, r_d_err;
  logic [31:0] r_f_rdata, r_d_rdata;
  logic        r_owner;
  logic        r_last;

  logic        w_pick_data;
  logic        w_timeout;
  logic        w_cnt_clear;
  logic        w_cnt_enable;

  // Data wins when it is the only requester, or on a tie when fetch won last.
  always_comb begin
    w_pick_data  = D_Req && (!F_Req || (r_last == OWNER_FETCH));
    w_cnt_clear  = (r_state != ST_ACCESS);
    w_cnt_enable = (r_state == ST_ACCESS);
  end

  access_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (Clock),
    .rst_n     (Reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_terminal(w_timeout)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_mov     <= 1'b0;
      r_rw      <= RW_READ;
      r_size    <= '0;
      r_su      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f_gnt   <= 1'b0;
      r_f_done  <= 1'b0;
      r_f_err   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
      r_owner   <= OWNER_FETCH;
      r_last    <= OWNER_DATA;
    end else begin
      r_f_gnt  <= 1'b0;
      r_f_done <= 1'b0;
      r_f_err  <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (F_Req || D_Req) begin
            r_state <= ST_ACCESS;
            r_mov   <= 1'b1;
            r_owner <= w_pick_data;
            r_last  <= w_pick_data;
            if (w_pick_data) begin
              r_addr  <= D_Addr;
              r_wdata <= D_WData;
              r_rw    <= D_RW;
              r_size  <= D_Size;
              r_su    <= D_SU;
              r_d_gnt <= 1'b1;
            end else begin
              r_addr  <= F_Addr;
              r_wdata <= '0;
              r_rw    <= RW_READ;
              r_size  <= SIZE_WORD;
              r_su    <= 1'b0;
              r_f_gnt <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // MOC takes priority over a timeout landing on the same cycle.
          if (MOC || w_timeout) begin
            r_state <= ST_RELEASE;
            r_mov   <= 1'b0;
            if (r_owner == OWNER_DATA) begin
              r_d_done <= 1'b1;
              r_d_err  <= !MOC;
              if (MOC && (r_rw != RW_WRITE)) begin
                r_d_rdata <= Mem_RData;
              end
            end else begin
              r_f_done <= 1'b1;
              r_f_err  <= !MOC;
              if (MOC && (r_rw != RW_WRITE)) begin
                r_f_rdata <= Mem_RData;
              end
            end
          end
        end
        ST_RELEASE: begin
          if (!MOC) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mov   <= 1'b0;
        end
      endcase
    end
  end

  assign F_Gnt     = r_f_gnt;
  assign F_Done    = r_f_done;
  assign F_Err     = r_f_err;
  assign F_RData   = r_f_rdata;
  assign D_Gnt     = r_d_gnt;
  assign D_Done    = r_d_done;
  assign D_Err     = r_d_err;
  assign D_RData   = r_d_rdata;
  assign MOV       = r_mov;
  assign RW        = r_rw;
  assign SIZE      = r_size;
  assign SU        = r_su;
  assign Mem_Addr  = r_addr;
  assign Mem_WData = r_wdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed transaction table, reset-in-access
// sequence and randomized transactions against a transaction-level model.
module tb_memory_port_arbiter;

  localparam int unsigned TO = 6;

  logic        Clock;
  logic        Reset;
  logic        F_Req;
  logic [31:0] F_Addr;
  logic        F_Gnt, F_Done, F_Err;
  logic [31:0] F_RData;
  logic        D_Req, D_RW, D_SU;
  logic [1:0]  D_Size;
  logic [31:0] D_Addr, D_WData;
  logic        D_Gnt, D_Done, D_Err;
  logic [31:0] D_RData;
  logic        MOV, RW, SU;
  logic [1:0]  SIZE;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
  logic        MOC;

  memory_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .F_Req(F_Req), .F_Addr(F_Addr), .F_Gnt(F_Gnt), .F_Done(F_Done), .F_Err(F_Err),
    .F_RData(F_RData),
    .D_Req(D_Req), .D_RW(D_RW), .D_Size(D_Size), .D_SU(D_SU), .D_Addr(D_Addr),
    .D_WData(D_WData), .D_Gnt(D_Gnt), .D_Done(D_Done), .D_Err(D_Err), .D_RData(D_RData),
    .MOV(MOV), .RW(RW), .SIZE(SIZE), .SU(SU), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .MOC(MOC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit          new_f;
    bit          new_d;
    logic [31:0] fa;
    bit          drw;
    logic [1:0]  dsz;
    bit          dsu;
    logic [31:0] da;
    logic [31:0] dwd;
    int unsigned k;       // MOC sampled on the k-th edge after grant
    int unsigned h;       // extra edges MOC stays high after Done
    logic [31:0] rd;
    bit          drop;    // winner drops Req right after grant
    bit          exp_wd;  // expected winner is data
    bit          exp_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model state
  bit          pf, pd, last_data;
  logic [31:0] fq_addr, dq_addr, dq_wd, exp_frd, exp_drd;
  bit          dq_rw, dq_su;
  logic [1:0]  dq_sz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    logic [31:0] e_addr, e_wd;
    logic        e_rw, e_su;
    logic [1:0]  e_sz;
    bit          moc_seen;
    int unsigned lim, hh;
    if (v.new_f) begin
      F_Req = 1'b1; F_Addr = v.fa; pf = 1'b1; fq_addr = v.fa;
    end
    if (v.new_d) begin
      D_Req = 1'b1; D_RW = v.drw; D_Size = v.dsz; D_SU = v.dsu; D_Addr = v.da; D_WData = v.dwd;
      pd = 1'b1; dq_rw = v.drw; dq_sz = v.dsz; dq_su = v.dsu; dq_addr = v.da; dq_wd = v.dwd;
    end
    if (v.exp_wd) begin
      e_addr = dq_addr; e_wd = dq_wd; e_rw = dq_rw; e_sz = dq_sz; e_su = dq_su; pd = 1'b0;
    end else begin
      e_addr = fq_addr; e_wd = '0; e_rw = 1'b1; e_sz = 2'b10; e_su = 1'b0; pf = 1'b0;
    end
    last_data = v.exp_wd;
    step();
    chk("grant", 32'({F_Gnt, D_Gnt}), 32'({~v.exp_wd, v.exp_wd}));
    chk("mov_at_grant", 32'(MOV), 32'(1));
    chk("mem_addr", Mem_Addr, e_addr);
    chk("mem_wdata", Mem_WData, e_wd);
    chk("mem_attr", 32'({RW, SIZE, SU}), 32'({e_rw, e_sz, e_su}));
    if (v.exp_wd) begin
      D_Addr = $urandom; D_WData = $urandom; D_RW = ~D_RW;
      if (v.drop) D_Req = 1'b0;
    end else begin
      F_Addr = $urandom;
      if (v.drop) F_Req = 1'b0;
    end
    moc_seen = (v.k <= TO + 1);
    lim = moc_seen ? v.k : TO + 1;
    for (int unsigned j = 1; j <= lim; j++) begin
      if (j == v.k) begin
        MOC = 1'b1; Mem_RData = v.rd;
      end else begin
        Mem_RData = $urandom;
      end
      step();
      if (j < lim) begin
        chk("mov_hold", 32'(MOV), 32'(1));
        chk("addr_hold", Mem_Addr, e_addr);
        chk("no_pulse", 32'({F_Gnt, D_Gnt, F_Done, D_Done}), 32'(0));
      end
    end
    chk("done", 32'({F_Done, D_Done}), 32'({~v.exp_wd, v.exp_wd}));
    chk("err", 32'({F_Err, D_Err}), v.exp_err ? 32'({~v.exp_wd, v.exp_wd}) : 32'(0));
    chk("mov_end", 32'({MOV, F_Gnt, D_Gnt}), 32'(0));
    if (!v.exp_err && e_rw) begin
      if (v.exp_wd) exp_drd = v.rd;
      else          exp_frd = v.rd;
    end
    chk("f_rdata", F_RData, exp_frd);
    chk("d_rdata", D_RData, exp_drd);
    if (v.exp_wd) D_Req = 1'b0;
    else          F_Req = 1'b0;
    hh = moc_seen ? v.h : 0;
    for (int unsigned j = 0; j < hh; j++) begin
      step();
      chk("release_hold", 32'({MOV, F_Gnt, D_Gnt, F_Done, D_Done}), 32'(0));
    end
    MOC = 1'b0;
    step();
    chk("release_exit", 32'({MOV, F_Gnt, D_Gnt, F_Done, D_Done}), 32'(0));
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'h0,   1'b0, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1, 0, 32'h11111111, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        3, 1, 32'h99999999, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h40,  1'b1, 2'b01, 1'b1, 32'h300, 32'h0,        2, 0, 32'h22222222, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        1, 0, 32'h33334444, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h100, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        2, 0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b00, 1'b0, 32'h500, 32'h12345678, TO + 5, 0, 32'hFFFF0000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h0,   1'b1, 2'b10, 1'b1, 32'h504, 32'h0,        TO + 1, 0, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h700, 1'b1, 2'b10, 1'b0, 32'h600, 32'h0,        1, 3, 32'h0BADC0DE, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h0,   1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        2, 0, 32'h5555AAAA, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h800, 1'b0, 2'b00, 1'b0, 32'h0,   32'h0,        TO + 3, 0, 32'h13579BDF, 1'b1, 1'b0, 1'b1};

    Reset = 1'b0; F_Req = 1'b0; F_Addr = '0; D_Req = 1'b0; D_RW = 1'b0; D_Size = '0; D_SU = 1'b0;
    D_Addr = '0; D_WData = '0; Mem_RData = '0; MOC = 1'b0;
    pf = 1'b0; pd = 1'b0; last_data = 1'b1; exp_frd = '0; exp_drd = '0;
    fq_addr = '0; dq_addr = '0; dq_wd = '0; dq_rw = 1'b0; dq_su = 1'b0; dq_sz = '0;

    step(); step();
    chk("rst_ctrl", 32'({MOV, RW, SIZE, SU}), 32'({1'b0, 1'b1, 2'b00, 1'b0}));
    chk("rst_addr", Mem_Addr, 32'h0);
    chk("rst_wdata", Mem_WData, 32'h0);
    chk("rst_pulses", 32'({F_Gnt, F_Done, F_Err, D_Gnt, D_Done, D_Err}), 32'(0));
    chk("rst_rdata", F_RData | D_RData, 32'h0);
    Reset = 1'b1;
    step();
    chk("idle_no_req", 32'({MOV, F_Gnt, D_Gnt}), 32'(0));

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Reset pulled mid-access, away from any clock edge
    F_Req = 1'b1; F_Addr = 32'h900;
    step();
    chk("rst_seq_gnt", 32'({F_Gnt, MOV}), 32'({1'b1, 1'b1}));
    step(); step();
    #2 Reset = 1'b0;
    #1;
    chk("rst_async_mov", 32'({MOV, F_Done, D_Done, F_Err}), 32'(0));
    chk("rst_async_addr", Mem_Addr, 32'h0);
    chk("rst_async_rdata", F_RData, 32'h0);
    step();
    chk("rst_no_done", 32'({MOV, F_Done, D_Done, F_Gnt}), 32'(0));
    #2 Reset = 1'b1;
    last_data = 1'b1; exp_frd = '0; exp_drd = '0; pd = 1'b0; pf = 1'b1; fq_addr = 32'h900;
    rv = '{1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2, 1, 32'h77778888, 1'b0, 1'b0, 1'b0};
    do_txn(rv);

    for (int i = 0; i < 40; i++) begin
      rv.new_f = !pf && ($urandom_range(0, 1) == 1);
      rv.new_d = !pd && (($urandom_range(0, 1) == 1) || (!pf && !rv.new_f));
      rv.fa    = $urandom;
      rv.drw   = 1'($urandom);
      rv.dsz   = 2'($urandom_range(0, 3));
      rv.dsu   = 1'($urandom);
      rv.da    = $urandom;
      rv.dwd   = $urandom;
      rv.k     = $urandom_range(1, TO + 3);
      rv.h     = $urandom_range(0, 2);
      rv.rd    = $urandom;
      rv.drop  = 1'($urandom);
      rv.exp_wd  = (pd || rv.new_d) && (!(pf || rv.new_f) || !last_data);
      rv.exp_err = (rv.k > TO + 1);
      do_txn(rv);
    end

    for (int i = 0; i < 2; i++) begin
      if (pf || pd) begin
        rv.new_f = 1'b0; rv.new_d = 1'b0; rv.k = 1; rv.h = 0; rv.rd = $urandom; rv.drop = 1'b0;
        rv.exp_wd = pd && (!pf || !last_data);
        rv.exp_err = 1'b0;
        do_txn(rv);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
